// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch controller slice.
// Provides the BCD time bundle, the mode enum and the time width.
package stopwatch_pkg;

  localparam int TIME_W = 16;

  typedef struct packed {
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic [3:0] ms1;
    logic [3:0] ms0;
  } bcd_time_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    PAUSE = 2'd3
  } sw_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: level accepted after DEBOUNCE_CYCLES stable samples.
// Ports: clk, rst (sync, active-low), btn in; level, press (1-cycle rise) out.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // Any sample equal to the accepted level restarts the count,
  // so a bounce back mid-count throws the partial count away.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (btn == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = btn;
      press_d = btn;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Two-button stopwatch mode FSM, hold timer, display freeze, lap buffer.
// Ports: clk, rst (sync, active-low), btn_ss, btn_lr, time_in in;
// sw_start/stop/reset, running, disp, frozen, lap_* out; lap_ready in.
// STOPWATCH_LAP_FIFO_EN: LAP_DEPTH-entry FIFO, else single lap register.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 150000000,
  parameter int LAP_DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_ss,
  input  logic                       btn_lr,
  input  logic [TIME_W-1:0]          time_in,
  output logic                       sw_start,
  output logic                       sw_stop,
  output logic                       sw_reset,
  output logic                       running,
  output logic [TIME_W-1:0]          disp,
  output logic                       frozen,
  output logic                       lap_valid,
  input  logic                       lap_ready,
  output logic [TIME_W-1:0]          lap_data,
  output logic [$clog2(LAP_DEPTH):0] lap_count,
  output logic                       lap_ovf
);

  localparam int CNT_W = $clog2(LAP_DEPTH) + 1;
  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  logic lvl_ss, lvl_lr, prs_ss, prs_lr;
  logic ev_ss, ev_lr;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_ss),
    .level (lvl_ss),
    .press (prs_ss)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_lr),
    .level (lvl_lr),
    .press (prs_lr)
  );

  // start/stop wins when both buttons land together
  assign ev_ss = prs_ss & lvl_ss;
  assign ev_lr = prs_lr & lvl_lr & ~ev_ss;

  sw_state_e state_q, state_d;
  logic      start_q, start_d;
  logic      stop_q, stop_d;
  logic      rstc_q, rstc_d;
  logic      frozen_q, frozen_d;
  bcd_time_t frz_q, frz_d;
  bcd_time_t live_q;
  logic [HW-1:0] hold_q, hold_d;
  logic      lap_cap, lap_flush;

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    rstc_d    = 1'b0;
    frozen_d  = frozen_q;
    frz_d     = frz_q;
    hold_d    = hold_q;
    lap_cap   = 1'b0;
    lap_flush = 1'b0;
    if (state_q == HOLD && hold_q != '0) hold_d = hold_q - 1'b1;
    unique case (state_q)
      IDLE: begin
        if (ev_ss) begin
          state_d = RUN;
          start_d = 1'b1;
        end else if (ev_lr) begin
          rstc_d    = 1'b1;
          lap_flush = 1'b1;
        end
      end
      RUN: begin
        if (ev_ss) begin
          state_d = PAUSE;
          stop_d  = 1'b1;
        end else if (ev_lr) begin
          state_d = HOLD;
          lap_cap = 1'b1;
        end
      end
      HOLD: begin
        // a press on the expiry cycle takes priority over release
        if (ev_ss) begin
          state_d  = PAUSE;
          stop_d   = 1'b1;
          frozen_d = 1'b0;
        end else if (ev_lr) begin
          lap_cap = 1'b1;
        end else if (hold_q == '0) begin
          state_d  = RUN;
          frozen_d = 1'b0;
        end
      end
      PAUSE: begin
        if (ev_ss) begin
          state_d = RUN;
          start_d = 1'b1;
        end else if (ev_lr) begin
          state_d   = IDLE;
          rstc_d    = 1'b1;
          lap_flush = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (lap_cap) begin
      frozen_d = 1'b1;
      frz_d    = time_in;
      hold_d   = HOLD_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      rstc_q   <= 1'b0;
      frozen_q <= 1'b0;
      frz_q    <= '0;
      live_q   <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      rstc_q   <= rstc_d;
      frozen_q <= frozen_d;
      frz_q    <= frz_d;
      live_q   <= time_in;
      hold_q   <= hold_d;
    end
  end

  assign sw_start = start_q;
  assign sw_stop  = stop_q;
  assign sw_reset = rstc_q;
  assign running  = (state_q == RUN) || (state_q == HOLD);
  assign frozen   = frozen_q;
  assign disp     = frozen_q ? frz_q : live_q;

`ifdef STOPWATCH_LAP_FIFO_EN
  localparam int PTR_W = $clog2(LAP_DEPTH);

  logic [TIME_W-1:0] mem_q [LAP_DEPTH];
  logic [TIME_W-1:0] mem_d [LAP_DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              full, pop, push_ok;

  // When full, a same-cycle pop frees the head slot that wp
  // points at, so the push lands there without loss.
  always_comb begin
    full    = (cnt_q == CNT_W'(LAP_DEPTH));
    pop     = (cnt_q != '0) && lap_ready;
    push_ok = lap_cap && (!full || pop);
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (lap_flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wp_q] = time_in;
        wp_d        = wp_q + 1'b1;
      end
      if (pop) rp_d = rp_q + 1'b1;
      if (lap_cap && !push_ok) ovf_d = 1'b1;
      unique case ({push_ok, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign lap_valid = (cnt_q != '0);
  assign lap_data  = lap_valid ? mem_q[rp_q] : '0;
  assign lap_count = cnt_q;
  assign lap_ovf   = ovf_q;
`else
  logic [TIME_W-1:0] lap_q, lap_d;
  logic              vld_q, vld_d;
  logic              ovf_q, ovf_d;
  logic              pop;

  always_comb begin
    pop   = vld_q && lap_ready;
    lap_d = lap_q;
    vld_d = vld_q;
    ovf_d = ovf_q;
    if (lap_flush) begin
      vld_d = 1'b0;
      ovf_d = 1'b0;
    end else if (lap_cap) begin
      lap_d = time_in;
      vld_d = 1'b1;
      if (vld_q && !pop) ovf_d = 1'b1;
    end else if (pop) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lap_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      lap_q <= lap_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
    end
  end

  assign lap_valid = vld_q;
  assign lap_data  = vld_q ? lap_q : '0;
  assign lap_count = CNT_W'(vld_q);
  assign lap_ovf   = ovf_q;
`endif

endmodule
